// File: rtl/isa_target_pkg.sv
// Shared types and register-map constants for the ISA I/O target.
package isa_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACCESS,
        ST_HOLD,
        ST_SKIP
    } state_t;

    localparam int REG_STATUS        = 0;
    localparam int REG_DOORBELL      = 1;
    localparam int STATUS_IRQ_BIT    = 0;
    localparam int STATUS_WCOUNT_LSB = 8;

    function automatic logic [15:0] status_word(input logic [7:0] wcount, input logic irq);
        logic [15:0] w;
        w = '0;
        w[STATUS_IRQ_BIT] = irq;
        w[STATUS_WCOUNT_LSB +: 8] = wcount;
        return w;
    endfunction

endpackage

// File: rtl/isa_strobe_sync.sv
// Two-flop synchroniser for an active-low bus strobe with assert (fall) and deassert (rise) pulses.
module isa_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic synced,
    output logic fall,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // Idle level of the strobe is high, so reset to high to avoid a false assert pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= strobe;
            sync <= meta;
            prev <= sync;
        end
    end

    assign synced = sync;
    assign fall   = prev & ~sync;
    assign rise   = ~prev & sync;

endmodule

// File: rtl/isa_io_target.sv
// ISA I/O target: window decode, strobe-driven access FSM with IOCHRDY wait states,
// small register bank with STATUS, DOORBELL/IRQ and scratch registers.
module isa_io_target
    import isa_target_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0220,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        global_reset,
    input  logic [15:0] A,
    input  logic [15:0] D_in,
    output logic [15:0] D_out,
    output logic        D_oe,
    input  logic        IOR,
    input  logic        IOW,
    input  logic        AEN,
    output logic        IOCHRDY,
    output logic        IRQ
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    logic ior_s, ior_fall, ior_rise;
    logic iow_s, iow_fall, iow_rise;

    isa_strobe_sync u_ior_sync (
        .clk    (clk),
        .rst_n  (global_reset),
        .strobe (IOR),
        .synced (ior_s),
        .fall   (ior_fall),
        .rise   (ior_rise)
    );

    isa_strobe_sync u_iow_sync (
        .clk    (clk),
        .rst_n  (global_reset),
        .strobe (IOW),
        .synced (iow_s),
        .fall   (iow_fall),
        .rise   (iow_rise)
    );

    state_t      state_q, state_d;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        aen_q;
    logic        rd_q;
    logic [7:0]  wait_cnt_q;
    logic [7:0]  wcount_q;
    logic [15:0] regs_q [NUM_REGS];

    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             act_done;
    logic             capture, wait_load, wait_dec, access, oe_clr, rdy_d;
    logic [15:0]      rd_data;

    assign hit = !aen_q && (addr_q[15:IDX_W] == BASE_ADDR[15:IDX_W]);
    assign idx = addr_q[IDX_W-1:0];

    // The strobe that opened the cycle has gone back high (level or fresh edge).
    assign act_done = rd_q ? (ior_s | ior_rise) : (iow_s | iow_rise);

    assign rd_data = (idx == IDX_W'(REG_STATUS)) ? status_word(wcount_q, IRQ) : regs_q[idx];

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        access    = 1'b0;
        oe_clr    = 1'b0;
        rdy_d     = IOCHRDY;
        case (state_q)
            ST_IDLE: begin
                if (!ior_s && !iow_s) begin
                    state_d = ST_SKIP;
                end else if (ior_fall ^ iow_fall) begin
                    state_d = ST_DECODE;
                    capture = 1'b1;
                end
            end
            ST_DECODE: begin
                if (act_done) begin
                    state_d = ST_IDLE;
                end else if (!hit) begin
                    state_d = ST_SKIP;
                end else if (WAIT_CYCLES == 0) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d   = ST_WAIT;
                    wait_load = 1'b1;
                    rdy_d     = 1'b0;
                end
            end
            ST_WAIT: begin
                if (act_done) begin
                    state_d = ST_IDLE;
                    rdy_d   = 1'b1;
                end else if (wait_cnt_q == 8'd0) begin
                    state_d = ST_ACCESS;
                    rdy_d   = 1'b1;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            ST_ACCESS: begin
                access  = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (act_done) begin
                    oe_clr  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SKIP: begin
                if (ior_s && iow_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            addr_q     <= '0;
            data_q     <= '0;
            aen_q      <= 1'b0;
            rd_q       <= 1'b0;
            wait_cnt_q <= '0;
            wcount_q   <= '0;
            D_out      <= '0;
            D_oe       <= 1'b0;
            IOCHRDY    <= 1'b1;
            IRQ        <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            IOCHRDY <= rdy_d;
            if (capture) begin
                addr_q <= A;
                data_q <= D_in;
                aen_q  <= AEN;
                rd_q   <= ior_fall;
            end
            if (wait_load) begin
                wait_cnt_q <= WAIT_LOAD;
            end else if (wait_dec) begin
                wait_cnt_q <= wait_cnt_q - 8'd1;
            end
            if (access) begin
                if (rd_q) begin
                    D_out <= rd_data;
                    D_oe  <= 1'b1;
                    if (idx == IDX_W'(REG_DOORBELL)) begin
                        IRQ <= 1'b0;
                    end
                end else if (idx != IDX_W'(REG_STATUS)) begin
                    regs_q[idx] <= data_q;
                    wcount_q    <= wcount_q + 8'd1;
                    if (idx == IDX_W'(REG_DOORBELL)) begin
                        IRQ <= 1'b1;
                    end
                end
            end
            if (oe_clr) begin
                D_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isa_io_target.sv
// Randomised bench for isa_io_target against a register-level reference model; a second
// instance without wait states shares the bus to confirm IOCHRDY never drops there.
module tb_isa_io_target;

    localparam logic [15:0] BASE = 16'h0220;

    logic        clk = 1'b0;
    logic        global_reset;
    logic [15:0] A, D_in;
    logic        IOR, IOW, AEN;
    logic [15:0] d_out, nw_d_out;
    logic        d_oe, nw_d_oe, iochrdy, nw_rdy, irq, nw_irq;

    isa_io_target #(.BASE_ADDR(16'h0220), .NUM_REGS(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .global_reset(global_reset), .A(A), .D_in(D_in), .D_out(d_out),
        .D_oe(d_oe), .IOR(IOR), .IOW(IOW), .AEN(AEN), .IOCHRDY(iochrdy), .IRQ(irq)
    );

    isa_io_target #(.BASE_ADDR(16'h0220), .NUM_REGS(8), .WAIT_CYCLES(0)) dut_nw (
        .clk(clk), .global_reset(global_reset), .A(A), .D_in(D_in), .D_out(nw_d_out),
        .D_oe(nw_d_oe), .IOR(IOR), .IOW(IOW), .AEN(AEN), .IOCHRDY(nw_rdy), .IRQ(nw_irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int nw_low   = 0;

    logic [15:0] m_regs [8];
    logic [7:0]  m_wcount;
    logic        m_irq;

    always @(negedge clk) if (!nw_rdy) nw_low++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_wcount = 8'h0;
        m_irq    = 1'b0;
    endtask

    function automatic bit is_hit(input logic [15:0] addr, input logic aen);
        return !aen && (addr[15:3] == BASE[15:3]);
    endfunction

    // One complete bus cycle: strobe held low for 10 clocks, then released for 5.
    task automatic io_cycle(input bit rd, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic aen, output logic [15:0] got);
        bit          hit;
        int          idx, low_cnt, first_low;
        logic [15:0] exp;
        hit = is_hit(addr, aen);
        idx = int'(addr[2:0]);
        exp = (idx == 0) ? {m_wcount, 7'b0, m_irq} : m_regs[idx];
        @(negedge clk);
        A = addr; D_in = wdata; AEN = aen;
        @(negedge clk);
        if (rd) IOR = 1'b0; else IOW = 1'b0;
        low_cnt = 0;
        first_low = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!iochrdy) begin
                if (first_low < 0) first_low = k;
                low_cnt++;
            end
        end
        got = d_out;
        chk("wait_len", low_cnt, hit ? 2 : 0);
        if (hit) chk("wait_start", first_low, 4);
        chk("oe_during", d_oe, rd && hit);
        chk("nw_oe_during", nw_d_oe, rd && hit);
        if (rd && hit) begin
            chk("rdata", d_out, exp);
            chk("nw_rdata", nw_d_out, exp);
        end
        IOR = 1'b1; IOW = 1'b1;
        repeat (5) @(negedge clk);
        chk("oe_after", d_oe, 0);
        chk("rdy_after", iochrdy, 1);
        if (hit) begin
            if (rd) begin
                if (idx == 1) m_irq = 1'b0;
            end else if (idx != 0) begin
                m_regs[idx] = wdata;
                m_wcount    = m_wcount + 8'd1;
                if (idx == 1) m_irq = 1'b1;
            end
        end
        chk("irq", irq, m_irq);
        chk("nw_irq", nw_irq, m_irq);
    endtask

    task automatic read_all(input string tag);
        logic [15:0] g;
        for (int i = 0; i < 8; i++) io_cycle(1, BASE + 16'(i), 16'h0, 1'b0, g);
    endtask

    initial begin
        logic [15:0] got;
        int          r;
        A = 16'h0; D_in = 16'h0; IOR = 1'b1; IOW = 1'b1; AEN = 1'b0;
        global_reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_dout", d_out, 0);
        chk("rst_oe", d_oe, 0);
        chk("rst_rdy", iochrdy, 1);
        chk("rst_irq", irq, 0);
        global_reset = 1'b1;
        repeat (2) @(negedge clk);

        io_cycle(0, 16'h0222, 16'h1234, 1'b0, got);
        io_cycle(1, 16'h0222, 16'h0, 1'b0, got);
        chk("scratch_rd", got, 16'h1234);
        io_cycle(1, 16'h0220, 16'h0, 1'b0, got);
        chk("status_wcount1", got[15:8], 8'h01);

        io_cycle(1, 16'h0300, 16'h0, 1'b0, got);
        io_cycle(0, 16'h0300, 16'hDEAD, 1'b0, got);
        io_cycle(0, 16'h0222, 16'h5555, 1'b1, got);
        io_cycle(1, 16'h0222, 16'h0, 1'b1, got);
        io_cycle(0, 16'h0220, 16'hFFFF, 1'b0, got);
        read_all("after_miss");

        io_cycle(0, 16'h0221, 16'hBEEF, 1'b0, got);
        chk("db_irq_set", irq, 1);
        io_cycle(0, 16'h0221, 16'hCAFE, 1'b0, got);
        io_cycle(1, 16'h0220, 16'h0, 1'b0, got);
        chk("status_irq", got[0], 1);
        io_cycle(1, 16'h0221, 16'h0, 1'b0, got);
        chk("db_rd", got, 16'hCAFE);
        chk("db_irq_clr", irq, 0);

        @(negedge clk);
        A = 16'h0223; D_in = 16'h7777; AEN = 1'b0;
        IOR = 1'b0; IOW = 1'b0;
        repeat (8) @(negedge clk);
        chk("skip_oe", d_oe, 0);
        chk("skip_rdy", iochrdy, 1);
        IOR = 1'b1; IOW = 1'b1;
        repeat (5) @(negedge clk);
        read_all("after_skip");

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       got = BASE + 16'(r);
            else if (r == 8) got = 16'h0300 + 16'($urandom_range(0, 15));
            else             got = BASE + 16'($urandom_range(0, 7));
            io_cycle($urandom_range(0, 1) == 1, got, 16'($urandom), r == 9, got);
        end
        read_all("after_random");

        for (int n = 0; n < 256; n++) io_cycle(0, 16'h0222, 16'($urandom), 1'b0, got);
        io_cycle(1, 16'h0220, 16'h0, 1'b0, got);
        chk("wcount_wrap", got[15:8], m_wcount);

        io_cycle(0, 16'h0221, 16'h00AA, 1'b0, got);
        @(negedge clk);
        A = 16'h0223; AEN = 1'b0;
        @(negedge clk);
        IOR = 1'b0;
        repeat (10) @(negedge clk);
        chk("hold_oe", d_oe, 1);
        global_reset = 1'b0;
        #1;
        chk("rst_hold_oe", d_oe, 0);
        chk("rst_hold_rdy", iochrdy, 1);
        chk("rst_hold_irq", irq, 0);
        @(negedge clk);
        IOR = 1'b1;
        repeat (3) @(negedge clk);
        global_reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        read_all("after_reset");

        chk("nw_never_wait", nw_low, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
